// File: rtl/karekok_hakem.sv
// karekok_hakem: round-robin arbiter/sequencer sharing one square-root unit
// between two requesters, with a bounded wait and timeout error reporting.
module karekok_hakem #(
  parameter int VERI_W      = 32,
  parameter int SONUC_W     = 64,
  parameter int ZAMAN_ASIMI = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               istek0_gecerli,
  input  logic [VERI_W-1:0]  istek0_sayi,
  output logic               istek0_kabul,
  output logic [SONUC_W-1:0] istek0_sonuc,
  output logic               istek0_sonuc_gecerli,
  output logic               istek0_hata,
  input  logic               istek1_gecerli,
  input  logic [VERI_W-1:0]  istek1_sayi,
  output logic               istek1_kabul,
  output logic [SONUC_W-1:0] istek1_sonuc,
  output logic               istek1_sonuc_gecerli,
  output logic               istek1_hata,
  output logic               birim_baslat,
  output logic [VERI_W-1:0]  birim_sayi,
  input  logic [SONUC_W-1:0] birim_sonuc,
  input  logic               birim_hazir,
  output logic               mesgul
);
  localparam int CW = $clog2(ZAMAN_ASIMI + 1);
  typedef enum logic [1:0] {BOSTA, BASLAT, BEKLE, YANIT} durum_t;
  durum_t durum, sonraki;
  logic sahip, isaretci, kazanan, istek_var, doldu, bitti;
  logic [CW-1:0] sayac;
  logic [VERI_W-1:0] sayi_r;
  logic [SONUC_W-1:0] sonuc_r [2];
  logic [1:0] hata_r;
  assign istek_var = istek0_gecerli || istek1_gecerli;
  assign kazanan = (istek0_gecerli && istek1_gecerli) ? isaretci : istek1_gecerli;
  assign doldu = sayac == CW'(ZAMAN_ASIMI);
  assign bitti = birim_hazir || doldu;
  always_comb begin
    sonraki = durum;
    case (durum)
      BOSTA:   sonraki = istek_var ? BASLAT : BOSTA;
      BASLAT:  sonraki = BEKLE;
      BEKLE:   sonraki = bitti ? YANIT : BEKLE;
      default: sonraki = BOSTA;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) durum <= BOSTA;
    else durum <= sonraki;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sahip <= 1'b0;
      isaretci <= 1'b0;
      sayac <= '0;
      sayi_r <= '0;
      sonuc_r[0] <= '0;
      sonuc_r[1] <= '0;
      hata_r <= '0;
    end else begin
      if (durum == BOSTA && istek_var) begin
        sahip <= kazanan;
        isaretci <= ~kazanan;
        sayi_r <= kazanan ? istek1_sayi : istek0_sayi;
      end
      if (durum == BASLAT) sayac <= '0;
      else if (durum == BEKLE && !doldu) sayac <= sayac + CW'(1);
      // a ready seen on the timeout edge still wins over the timeout
      if (durum == BEKLE && bitti) begin
        sonuc_r[sahip] <= birim_hazir ? birim_sonuc : '0;
        hata_r[sahip] <= !birim_hazir;
      end
    end
  end
  assign birim_baslat = durum == BASLAT;
  assign istek0_kabul = birim_baslat && !sahip;
  assign istek1_kabul = birim_baslat && sahip;
  assign istek0_sonuc_gecerli = durum == YANIT && !sahip;
  assign istek1_sonuc_gecerli = durum == YANIT && sahip;
  assign istek0_sonuc = sonuc_r[0];
  assign istek1_sonuc = sonuc_r[1];
  assign istek0_hata = hata_r[0];
  assign istek1_hata = hata_r[1];
  assign birim_sayi = sayi_r;
  assign mesgul = durum != BOSTA;
endmodule
